// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel image pipeline pixel buffers.
package sobel_pkg;

  localparam int PIXELS_PER_BUF = 4;

  typedef logic [PIXELS_PER_BUF-1:0][7:0]  gray_buf_t;
  typedef logic [PIXELS_PER_BUF-1:0][23:0] rgb_buf_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    DONE = 2'd2
  } pack_state_t;

endpackage

// File: rtl/gray_pixel_map.sv
// Per-pixel gray mapping: optional binarize against THRESHOLD, then optional invert.
module gray_pixel_map #(
  parameter int THRESHOLD = 0,
  parameter int INVERT    = 0
) (
  input  logic [7:0] gray_in,
  output logic [7:0] gray_out
);

  localparam logic [7:0] THRESHOLD_8 = 8'(THRESHOLD);

  logic [7:0] thresholded;

  // Threshold of zero means pass-through; invert never overflows since 255 - t >= 0.
  always_comb begin
    thresholded = gray_in;
    if (THRESHOLD != 0) begin
      thresholded = (gray_in >= THRESHOLD_8) ? 8'hFF : 8'h00;
    end
    gray_out = (INVERT != 0) ? (8'hFF - thresholded) : thresholded;
  end

endmodule

// File: rtl/gray_to_rgb_packer.sv
// Expands four captured gray pixels into four {v,v,v} RGB pixels, one per cycle,
// with an enable/done/ack handshake toward the output image writer.
module gray_to_rgb_packer
  import sobel_pkg::*;
#(
  parameter int THRESHOLD = 0,
  parameter int INVERT    = 0
) (
  input  logic      clk,
  input  logic      n_rst,
  input  gray_buf_t gray_pixel,
  input  logic      pack_en,
  input  logic      pack_ack,
  output rgb_buf_t  out_pixel_buffer,
  output logic      pack_done,
  output logic      pack_busy
);

  pack_state_t state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  gray_buf_t   gray_q, gray_d;
  rgb_buf_t    out_q, out_d;
  logic [7:0]  map_in, map_out;

  assign map_in = gray_q[idx_q];

  gray_pixel_map #(
    .THRESHOLD (THRESHOLD),
    .INVERT    (INVERT)
  ) u_map (
    .gray_in  (map_in),
    .gray_out (map_out)
  );

  // State, index, captured input and output buffer registers; reset discards everything.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      gray_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gray_q  <= gray_d;
      out_q   <= out_d;
    end
  end

  // Next-state logic: capture on start, write one mapped pixel per cycle, hold until acknowledged.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gray_d  = gray_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (pack_en) begin
          gray_d  = gray_pixel;
          out_d   = '0;
          idx_d   = 2'd0;
          state_d = PACK;
        end
      end
      PACK: begin
        out_d[idx_q] = {map_out, map_out, map_out};
        idx_d        = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (pack_ack) begin
          if (pack_en) begin
            gray_d  = gray_pixel;
            out_d   = '0;
            idx_d   = 2'd0;
            state_d = PACK;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  assign out_pixel_buffer = out_q;
  assign pack_done        = (state_q == DONE);
  assign pack_busy        = (state_q == PACK);

endmodule

// File: tb/tb_gray_to_rgb_packer.sv
// Directed bench: one pass-through instance and one THRESHOLD=128/INVERT=1 instance share stimulus.
module tb_gray_to_rgb_packer;
  import sobel_pkg::*;

  typedef struct {
    gray_buf_t gray;
    rgb_buf_t  exp_pass;
    rgb_buf_t  exp_thr;
  } vec_t;

  logic      tb_clk = 1'b0;
  logic      n_rst;
  gray_buf_t gray_pixel;
  logic      pack_en;
  logic      pack_ack;
  rgb_buf_t  out_pass, out_thr;
  logic      done_pass, done_thr;
  logic      busy_pass, busy_thr;

  int checks = 0;
  int errors = 0;
  vec_t vecs[4];

  gray_to_rgb_packer u_dut_pass (
    .clk              (tb_clk),
    .n_rst            (n_rst),
    .gray_pixel       (gray_pixel),
    .pack_en          (pack_en),
    .pack_ack         (pack_ack),
    .out_pixel_buffer (out_pass),
    .pack_done        (done_pass),
    .pack_busy        (busy_pass)
  );

  gray_to_rgb_packer #(
    .THRESHOLD (128),
    .INVERT    (1)
  ) u_dut_thr (
    .clk              (tb_clk),
    .n_rst            (n_rst),
    .gray_pixel       (gray_pixel),
    .pack_en          (pack_en),
    .pack_ack         (pack_ack),
    .out_pixel_buffer (out_thr),
    .pack_done        (done_thr),
    .pack_busy        (busy_thr)
  );

  always #5 tb_clk = ~tb_clk;

  // Advance one rising edge and settle slightly after it.
  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkFlags(input string name, input logic done_exp, input logic busy_exp);
    checkOutput({name, " done_pass"}, 96'(done_pass), 96'(done_exp));
    checkOutput({name, " busy_pass"}, 96'(busy_pass), 96'(busy_exp));
    checkOutput({name, " done_thr"},  96'(done_thr),  96'(done_exp));
    checkOutput({name, " busy_thr"},  96'(busy_thr),  96'(busy_exp));
  endtask

  // Drive a capture edge with pack_en high, then drop pack_en.
  task automatic applyStimulus(input gray_buf_t g);
    gray_pixel = g;
    pack_en    = 1'b1;
    tick();
    pack_en    = 1'b0;
  endtask

  // Count edges until pack_done rises, bounded so a stuck DUT still reaches the summary.
  task automatic waitDone(output int n);
    n = 0;
    while (!done_pass && n < 12) begin
      tick();
      n++;
    end
  endtask

  task automatic ackDone();
    pack_ack = 1'b1;
    tick();
    pack_ack = 1'b0;
  endtask

  initial begin
    int n;
    rgb_buf_t held;

    vecs[0] = '{gray: {8'd144, 8'd144, 8'd144, 8'd255},
                exp_pass: {24'h909090, 24'h909090, 24'h909090, 24'hFFFFFF},
                exp_thr:  {24'h000000, 24'h000000, 24'h000000, 24'h000000}};
    vecs[1] = '{gray: {8'd127, 8'd128, 8'd0, 8'd200},
                exp_pass: {24'h7F7F7F, 24'h808080, 24'h000000, 24'hC8C8C8},
                exp_thr:  {24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000}};
    vecs[2] = '{gray: {8'd1, 8'd2, 8'd3, 8'd4},
                exp_pass: {24'h010101, 24'h020202, 24'h030303, 24'h040404},
                exp_thr:  {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF}};
    vecs[3] = '{gray: {8'd0, 8'd255, 8'd127, 8'd128},
                exp_pass: {24'h000000, 24'hFFFFFF, 24'h7F7F7F, 24'h808080},
                exp_thr:  {24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000}};

    n_rst      = 1'b0;
    pack_en    = 1'b0;
    pack_ack   = 1'b0;
    gray_pixel = '0;
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    checkOutput("reset out_pass", 96'(out_pass), 96'(0));
    checkOutput("reset out_thr",  96'(out_thr),  96'(0));
    checkFlags("reset", 1'b0, 1'b0);

    // Table-driven vectors; gray_pixel is scrambled after capture to prove it is not re-read.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].gray);
      gray_pixel = ~vecs[i].gray;
      checkFlags($sformatf("vec%0d capture", i), 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d cleared", i), 96'(out_pass), 96'(0));
      waitDone(n);
      checkOutput($sformatf("vec%0d latency", i), 96'(n), 96'(4));
      checkFlags($sformatf("vec%0d done", i), 1'b1, 1'b0);
      checkOutput($sformatf("vec%0d out_pass", i), 96'(out_pass), 96'(vecs[i].exp_pass));
      checkOutput($sformatf("vec%0d out_thr", i),  96'(out_thr),  96'(vecs[i].exp_thr));
      ackDone();
      checkFlags($sformatf("vec%0d after ack", i), 1'b0, 1'b0);
    end

    // Hold in DONE without ack while pack_en is high; output must stay put.
    applyStimulus(vecs[0].gray);
    waitDone(n);
    checkOutput("hold latency", 96'(n), 96'(4));
    held = out_pass;
    pack_en    = 1'b1;
    gray_pixel = vecs[2].gray;
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput($sformatf("hold%0d out_pass", c), 96'(out_pass), 96'(vecs[0].exp_pass));
      checkOutput($sformatf("hold%0d stable", c), 96'(out_pass), 96'(held));
      checkFlags($sformatf("hold%0d", c), 1'b1, 1'b0);
    end

    // Back-to-back: ack and enable together recapture; done is low for exactly four samples.
    pack_ack = 1'b1;
    tick();
    pack_ack   = 1'b0;
    pack_en    = 1'b0;
    gray_pixel = '0;
    checkOutput("b2b cleared", 96'(out_pass), 96'(0));
    for (int c = 0; c < 4; c++) begin
      checkFlags($sformatf("b2b low%0d", c), 1'b0, 1'b1);
      tick();
    end
    checkFlags("b2b done", 1'b1, 1'b0);
    checkOutput("b2b out_pass", 96'(out_pass), 96'(vecs[2].exp_pass));
    checkOutput("b2b out_thr",  96'(out_thr),  96'(vecs[2].exp_thr));
    ackDone();

    // pack_en pulse and new gray data during PACK are ignored; stray ack in PACK too.
    applyStimulus(vecs[1].gray);
    gray_pixel = {8'd200, 8'd200, 8'd200, 8'd200};
    pack_en    = 1'b1;
    pack_ack   = 1'b1;
    tick();
    pack_en  = 1'b0;
    pack_ack = 1'b0;
    waitDone(n);
    checkOutput("ignore latency", 96'(n + 1), 96'(4));
    checkOutput("ignore out_pass", 96'(out_pass), 96'(vecs[1].exp_pass));
    checkOutput("ignore out_thr",  96'(out_thr),  96'(vecs[1].exp_thr));
    ackDone();

    // Abort mid-PACK once idx has reached 2.
    applyStimulus(vecs[0].gray);
    tick();
    tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    checkOutput("abort out_pass", 96'(out_pass), 96'(0));
    checkOutput("abort out_thr",  96'(out_thr),  96'(0));
    checkFlags("abort", 1'b0, 1'b0);
    tick();
    tick();
    checkFlags("abort idle", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
